// File: rtl/puneh_mem_arbiter.sv
// puneh_mem_arbiter
//   Arbitrates the single-ported PUNEH main memory between the CPU controller
//   datapath (port C) and the DMA/program loader (port D). The winning request
//   is latched, driven to memory for MEM_LAT ACCESS cycles, and completed with a
//   one-cycle ack on the winning port. Inputs are only sampled in IDLE.
//
//   Parameters: AW address width, DW data width, MEM_LAT read latency (1..15),
//               CPU_PRIO 0 = round-robin, 1 = fixed priority to C.
//   Ports:
//     clk, rst                  clock (rising edge), async active-high reset
//     i_c_req/we/addr/wdata     CPU request, held until o_c_ack
//     o_c_ack, o_c_rdata        CPU completion pulse / read data (held)
//     i_d_*, o_d_*              same for the DMA port
//     o_mem_en/we/addr/wdata    memory control (addr/wdata registered)
//     i_mem_rdata               memory read data
//     o_busy, o_grant_id        state != IDLE, current winner (0 = C, 1 = D)

// Per-port completion logic: read-data register and ack gating.
module puneh_mem_arbiter_port #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sel,       // this port owns the current transaction
  input  logic          i_ack_st,    // FSM is in ACK
  input  logic          i_cap,       // last ACCESS cycle of a read
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_ack,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_rdata <= '0;
    else if (i_sel && i_cap) r_rdata <= i_mem_rdata;
  end

  assign o_ack   = i_sel & i_ack_st;
  assign o_rdata = r_rdata;
endmodule

module puneh_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MEM_LAT  = 2,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_ack,
  output logic [DW-1:0] o_c_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_ack,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_grant_id
);
  localparam int         NP       = 2;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t                 r_state, w_nxt;
  req_t                   r_txn;
  logic [3:0]             r_cnt;
  logic                   r_gnt;
  logic                   r_last;   // port granted most recently
  logic [NP-1:0]          w_req;
  req_t [NP-1:0]          w_rq;
  logic                   w_win;
  logic                   w_start;
  logic                   w_cap;
  logic                   w_ack_st;
  logic [NP-1:0]          w_ack;
  logic [NP-1:0][DW-1:0]  w_rdata;

  assign w_req   = {i_d_req, i_c_req};
  assign w_rq[0] = {i_c_we, i_c_addr, i_c_wdata};
  assign w_rq[1] = {i_d_we, i_d_addr, i_d_wdata};

  // Winner: a lone requester wins; on a tie C wins under fixed priority,
  // otherwise the port that did not win last time.
  always_comb begin
    w_win = 1'b0;
    if (!w_req[0])                       w_win = 1'b1;
    else if (w_req[1] && CPU_PRIO == 0)  w_win = ~r_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_start  = 1'b0;
    w_cap    = 1'b0;
    o_mem_en = 1'b0;
    o_mem_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_start = 1'b1;
          w_nxt   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_en = 1'b1;
        // write strobe only on the first ACCESS cycle
        o_mem_we = r_txn.we && (r_cnt == 4'd0);
        if (r_cnt == LAST_CNT) begin
          w_cap = 1'b1;
          w_nxt = S_ACK;
        end
      end
      S_ACK:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn  <= '0;
      r_cnt  <= 4'd0;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;   // D, so C wins the first tie
    end else begin
      if (w_start) begin
        r_txn <= w_rq[w_win];
        r_gnt <= w_win;
        r_cnt <= 4'd0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_ACK) r_last <= r_gnt;
    end
  end

  assign w_ack_st = (r_state == S_ACK);

  for (genvar p = 0; p < NP; p++) begin : g_port
    puneh_mem_arbiter_port #(.DW(DW)) u_port (
      .clk        (clk),
      .rst        (rst),
      .i_sel      (r_gnt == 1'(p)),
      .i_ack_st   (w_ack_st),
      .i_cap      (w_cap & ~r_txn.we),
      .i_mem_rdata(i_mem_rdata),
      .o_ack      (w_ack[p]),
      .o_rdata    (w_rdata[p])
    );
  end

  assign o_c_ack     = w_ack[0];
  assign o_d_ack     = w_ack[1];
  assign o_c_rdata   = w_rdata[0];
  assign o_d_rdata   = w_rdata[1];
  assign o_mem_addr  = r_txn.addr;
  assign o_mem_wdata = r_txn.wdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_grant_id  = r_gnt;
endmodule

// File: tb/tb_puneh_mem_arbiter.sv
// Bench for puneh_mem_arbiter: dut0 = round-robin, MEM_LAT=2 with a registered
// memory model; dut1 = CPU priority, MEM_LAT=1 with a combinational model.
module tb_puneh_mem_arbiter;
  logic clk = 1'b0;
  logic rst, pre;
  always #5 clk = ~clk;

  // [dut][port] where port 0 = C, 1 = D
  logic [1:0][1:0]        req, we, ack;
  logic [1:0][1:0][15:0]  addr, wdata, rdata, hold;
  logic [1:0]             mem_en, mem_we, busy, gid;
  logic [1:0][15:0]       mem_addr, mem_wdata, mem_rdata;
  logic [15:0]            mem [2][256];
  logic [15:0]            rd0q;
  int pass = 0;
  int total = 0;

  puneh_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .CPU_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_c_req(req[0][0]), .i_c_we(we[0][0]), .i_c_addr(addr[0][0]), .i_c_wdata(wdata[0][0]),
    .o_c_ack(ack[0][0]), .o_c_rdata(rdata[0][0]),
    .i_d_req(req[0][1]), .i_d_we(we[0][1]), .i_d_addr(addr[0][1]), .i_d_wdata(wdata[0][1]),
    .o_d_ack(ack[0][1]), .o_d_rdata(rdata[0][1]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_busy(busy[0]), .o_grant_id(gid[0]));

  puneh_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .CPU_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_c_req(req[1][0]), .i_c_we(we[1][0]), .i_c_addr(addr[1][0]), .i_c_wdata(wdata[1][0]),
    .o_c_ack(ack[1][0]), .o_c_rdata(rdata[1][0]),
    .i_d_req(req[1][1]), .i_d_we(we[1][1]), .i_d_addr(addr[1][1]), .i_d_wdata(wdata[1][1]),
    .o_d_ack(ack[1][1]), .o_d_rdata(rdata[1][1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_busy(busy[1]), .o_grant_id(gid[1]));

  // Memory models: 0x0040 preloaded with 0xBEEF, everything else 0.
  always @(posedge clk) begin
    if (pre) begin
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 256; i++)
          mem[u][i] <= (i == 64) ? 16'hBEEF : 16'h0000;
    end else begin
      for (int u = 0; u < 2; u++)
        if (mem_en[u] && mem_we[u]) mem[u][mem_addr[u][7:0]] <= mem_wdata[u];
    end
    if (mem_en[0]) rd0q <= mem[0][mem_addr[0][7:0]];
  end
  assign mem_rdata[0] = rd0q;
  assign mem_rdata[1] = mem[1][mem_addr[1][7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else pass++;
  endtask

  // One isolated transaction with cycle-exact checks. pert: after the first
  // ACCESS cycle, drop req and scramble the request fields.
  task automatic txn(input int u, input int p, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] e, input logic pert);
    int   lat = (u == 0) ? 2 : 1;
    logic ew;
    req[u][p] = 1'b1; we[u][p] = w; addr[u][p] = a; wdata[u][p] = d;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      ew = (k == 0) ? w : 1'b0;
      chk("acc_ctl", 32'({mem_en[u], mem_we[u], busy[u], gid[u], ack[u]}),
                     32'({1'b1, ew, 1'b1, 1'(p), 2'b00}));
      chk("acc_addr", 32'(mem_addr[u]), 32'(a));
      if (w) chk("acc_wdata", 32'(mem_wdata[u]), 32'(d));
      if (pert) begin
        req[u][p] = 1'b0; addr[u][p] = ~a; wdata[u][p] = ~d; we[u][p] = ~w;
      end
    end
    @(posedge clk); #1;
    chk("ack_ctl", 32'({mem_en[u], busy[u], gid[u], ack[u]}),
                   32'({1'b0, 1'b1, 1'(p), 2'(2'b01 << p)}));
    chk("rdata", 32'(rdata[u][p]), 32'(e));
    chk("rdata_hold", 32'(rdata[u][1-p]), 32'(hold[u][1-p]));
    hold[u][p] = e;
    req[u][p]  = 1'b0;
    @(posedge clk); #1;
    chk("idle", 32'({busy[u], ack[u]}), 32'(0));
  endtask

  typedef struct {
    int          u;
    int          p;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] e;     // expected rdata of port p after its ack
    logic        pert;
  } vec_t;

  initial begin
    vec_t tbl [12];
    int   n, cyc, lastc, rp, nc, fd, nde, nack;

    tbl[0]  = '{0, 0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0};
    tbl[1]  = '{0, 1, 1'b1, 16'h00FF, 16'h1234, 16'h0000, 1'b0};
    tbl[2]  = '{0, 0, 1'b0, 16'h00FF, 16'h0000, 16'h1234, 1'b1};
    tbl[3]  = '{0, 0, 1'b1, 16'h0010, 16'hAAAA, 16'h1234, 1'b0};
    tbl[4]  = '{0, 1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 1'b0};
    tbl[5]  = '{0, 1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1};
    tbl[6]  = '{0, 0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b0};
    tbl[7]  = '{0, 1, 1'b1, 16'h0040, 16'h5555, 16'hBEEF, 1'b1};
    tbl[8]  = '{0, 0, 1'b0, 16'h0040, 16'h0000, 16'h5555, 1'b0};
    tbl[9]  = '{1, 0, 1'b1, 16'h0005, 16'hCAFE, 16'h0000, 1'b0};
    tbl[10] = '{1, 1, 1'b0, 16'h0005, 16'h0000, 16'hCAFE, 1'b0};
    tbl[11] = '{1, 0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1};

    rst = 1'b1; pre = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'({mem_en, mem_we, busy, gid, ack}), 32'(0));
    chk("reset_mem", 32'({mem_addr[0], mem_wdata[1]}), 32'(0));
    chk("reset_rdata", 32'({rdata[0][0], rdata[1][1]}), 32'(0));
    pre = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      txn(tbl[i].u, tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].pert);

    // Reset during the 2nd ACCESS cycle of a D write on dut0.
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 16'h0020; wdata[0][1] = 16'h7777;
    @(posedge clk); #1;
    chk("rst_acc1", 32'({mem_en[0], mem_we[0]}), 32'(2'b11));
    @(posedge clk); #1;
    chk("rst_acc2", 32'({mem_en[0], mem_we[0], busy[0]}), 32'(3'b101));
    #2 rst = 1'b1;
    #1;
    chk("rst_ctl", 32'({mem_en, mem_we, busy, gid, ack}), 32'(0));
    chk("rst_mem", 32'({mem_addr[0], mem_wdata[0]}), 32'(0));
    chk("rst_rdata", 32'({rdata[0][0], rdata[0][1]}), 32'(0));
    req[0][1] = 1'b0; hold = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack[0] != 2'b00) nack++;
    end
    chk("rst_no_ack", 32'(nack), 32'(0));

    // Round-robin with both ports continuously requesting: C,D,C,D.
    req[0] = 2'b11; we[0] = 2'b00; addr[0][0] = 16'h0040; addr[0][1] = 16'h0010;
    n = 0; cyc = 0; lastc = 0; rp = -1;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (rp >= 0) begin req[0][rp] = 1'b1; rp = -1; end
      if (ack[0] != 2'b00) begin
        chk("rr_grant", 32'(ack[0]), 32'(2'(2'b01 << (n % 2))));
        if (n == 0) chk("rr_first_lat", 32'(cyc), 32'(3));
        else        chk("rr_gap", 32'(cyc - lastc), 32'(4));
        lastc = cyc;
        rp = ack[0][1] ? 1 : 0;
        req[0][rp] = 1'b0;
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'(4));
    req[0] = 2'b00;
    repeat (5) @(posedge clk);
    #1;

    // Fixed priority on dut1: C starves D until c_req drops at cycle 20.
    req[1] = 2'b11; we[1] = 2'b00; addr[1][0] = 16'h0005; addr[1][1] = 16'h0040;
    cyc = 0; rp = -1; nc = 0; fd = 0; nde = 0;
    for (int k = 0; k < 26; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 20) begin req[1][0] = 1'b0; rp = -1; end
      else if (rp >= 0) begin req[1][0] = 1'b1; rp = -1; end
      if (ack[1][0]) begin
        nc++;
        req[1][0] = 1'b0;
        if (cyc < 20) rp = 0;
      end
      if (ack[1][1] && cyc < 21) nde++;
      if (ack[1][1] && fd == 0) fd = cyc;
    end
    chk("prio_c_acks", 32'(nc), 32'(7));
    chk("prio_no_d_early", 32'(nde), 32'(0));
    chk("prio_d_ack_cycle", 32'(fd), 32'(23));
    req[1] = 2'b00;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
